// File: rtl/imem_write_sched.sv
// imem_write_sched -- instruction-memory write scheduler.
// Serialises writes from a program loader and a QED shim onto a single RAM
// write port, and holds the core in reset until loading has finished.
//   LOAD : only the loader is served; ld_done moves to HOLD.
//   HOLD : nobody is served for HOLD_CYCLES cycles, then RUN.
//   RUN  : round-robin between loader and QED; ld_done is ignored.
// Ports:
//   CLK, RESET                  clock, asynchronous active-high reset
//   ld_vld/ld_addr/ld_data      loader write request
//   ld_done                     loader end-of-program pulse
//   ld_rdy                      loader request accepted this cycle
//   qed_vld/qed_addr/qed_data   QED shim write request
//   qed_rdy                     QED request accepted this cycle
//   mem_addr/mem_data/mem_we    registered RAM port-A write (one cycle after grant)
//   core_reset                  registered active-high reset to the core
//   wr_count                    saturating count of RAM writes since reset
module imem_write_sched #(
  parameter int HOLD_CYCLES = 4,
  parameter int AW          = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ld_vld,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_done,
  output logic          ld_rdy,
  input  logic          qed_vld,
  input  logic [AW-1:0] qed_addr,
  input  logic [31:0]   qed_data,
  output logic          qed_rdy,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_data,
  output logic [3:0]    mem_we,
  output logic          core_reset,
  output logic [15:0]   wr_count
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

  state_t        state_r;
  logic [3:0]    hold_cnt_r;
  logic          favor_qed_r;   // 1: QED wins the next tie
  logic [AW-1:0] mem_addr_r;
  logic [31:0]   mem_data_r;
  logic [3:0]    mem_we_r;
  logic          core_reset_r;
  logic [15:0]   wr_count_r;

  logic ld_gnt_s;
  logic qed_gnt_s;
  logic any_gnt_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Grant decode: state- and pointer-dependent, forced low during reset.
  always_comb begin
    ld_gnt_s  = 1'b0;
    qed_gnt_s = 1'b0;
    if (RESET) begin
      ld_gnt_s  = 1'b0;
      qed_gnt_s = 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          ld_gnt_s  = ld_vld;
          qed_gnt_s = 1'b0;
        end
        HOLD: begin
          ld_gnt_s  = 1'b0;
          qed_gnt_s = 1'b0;
        end
        RUN: begin
          if (ld_vld && qed_vld) begin
            // Tie: the requester not granted last wins.
            qed_gnt_s = favor_qed_r;
            ld_gnt_s  = ~favor_qed_r;
          end else begin
            ld_gnt_s  = ld_vld;
            qed_gnt_s = qed_vld;
          end
        end
        default: begin
          ld_gnt_s  = 1'b0;
          qed_gnt_s = 1'b0;
        end
      endcase
    end
  end

  assign any_gnt_s = ld_gnt_s | qed_gnt_s;

  // FSM, arbitration pointer and registered RAM/core outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r      <= LOAD;
      hold_cnt_r   <= 4'd0;
      favor_qed_r  <= 1'b1;
      mem_addr_r   <= '0;
      mem_data_r   <= 32'd0;
      mem_we_r     <= 4'h0;
      core_reset_r <= 1'b1;
      wr_count_r   <= 16'd0;
    end else begin
      mem_we_r <= any_gnt_s ? 4'hF : 4'h0;
      if (any_gnt_s) begin
        mem_addr_r <= ld_gnt_s ? ld_addr : qed_addr;
        mem_data_r <= ld_gnt_s ? ld_data : qed_data;
        wr_count_r <= sat_inc(wr_count_r);
      end
      case (state_r)
        LOAD: begin
          core_reset_r <= 1'b1;
          if (ld_done) begin
            state_r    <= HOLD;
            hold_cnt_r <= HOLD_INIT;
          end
        end
        HOLD: begin
          // core_reset drops on the same edge the FSM enters RUN.
          if (hold_cnt_r <= 4'd1) begin
            state_r      <= RUN;
            hold_cnt_r   <= 4'd0;
            core_reset_r <= 1'b0;
          end else begin
            hold_cnt_r   <= hold_cnt_r - 4'd1;
            core_reset_r <= 1'b1;
          end
        end
        RUN: begin
          core_reset_r <= 1'b0;
          // Pointer moves only on a grant: after an LD grant, favour QED.
          if (any_gnt_s) begin
            favor_qed_r <= ld_gnt_s;
          end
        end
        default: begin
          state_r      <= LOAD;
          core_reset_r <= 1'b1;
        end
      endcase
    end
  end

  assign ld_rdy     = ld_gnt_s;
  assign qed_rdy    = qed_gnt_s;
  assign mem_addr   = mem_addr_r;
  assign mem_data   = mem_data_r;
  assign mem_we     = mem_we_r;
  assign core_reset = core_reset_r;
  assign wr_count   = wr_count_r;

endmodule

// File: tb/tb_imem_write_sched.sv
// Directed, table-driven bench for imem_write_sched, with hand-written
// sequences for asynchronous reset, same-cycle ld_vld/ld_done and HOLD_CYCLES=1.
module tb_imem_write_sched;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ld_vld, ld_done, qed_vld;
  logic [4:0]  ld_addr, qed_addr;
  logic [31:0] ld_data, qed_data;
  logic        ld_rdy, qed_rdy, core_reset;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_we;
  logic [15:0] wr_count;

  // second instance with HOLD_CYCLES = 1
  logic        r1, l1_vld, l1_done, q1_vld;
  logic [4:0]  l1_addr, q1_addr;
  logic [31:0] l1_data, q1_data;
  logic        l1_rdy, q1_rdy, cr1;
  logic [4:0]  m1_addr;
  logic [31:0] m1_data;
  logic [3:0]  m1_we;
  logic [15:0] c1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  imem_write_sched #(.HOLD_CYCLES(4), .AW(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done), .ld_rdy(ld_rdy),
    .qed_vld(qed_vld), .qed_addr(qed_addr), .qed_data(qed_data), .qed_rdy(qed_rdy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .core_reset(core_reset), .wr_count(wr_count)
  );

  imem_write_sched #(.HOLD_CYCLES(1), .AW(5)) dut1 (
    .CLK(CLK), .RESET(r1),
    .ld_vld(l1_vld), .ld_addr(l1_addr), .ld_data(l1_data), .ld_done(l1_done), .ld_rdy(l1_rdy),
    .qed_vld(q1_vld), .qed_addr(q1_addr), .qed_data(q1_data), .qed_rdy(q1_rdy),
    .mem_addr(m1_addr), .mem_data(m1_data), .mem_we(m1_we),
    .core_reset(cr1), .wr_count(c1)
  );

  typedef struct {
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        dn;
    logic        qv;
    logic [4:0]  qa;
    logic [31:0] qd;
    logic        e_lr;
    logic        e_qr;
    logic [3:0]  e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_cr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [4:0] la, input logic [31:0] ldat, input logic dn,
                       input logic qv, input logic [4:0] qa, input logic [31:0] qdat);
    ld_vld = lv; ld_addr = la; ld_data = ldat; ld_done = dn;
    qed_vld = qv; qed_addr = qa; qed_data = qdat;
  endtask

  initial begin
    // {lv, la, ld, dn, qv, qa, qd,  ld_rdy, qed_rdy, we, addr, data, core_reset, wr_count}
    // Load three words, then ld_done; QED requests throughout are ignored.
    vecs[0]  = '{1'b1, 5'd0, 32'h00000013, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b1, 1'b0, 4'hF, 5'd0, 32'h00000013, 1'b1, 16'd1};
    vecs[1]  = '{1'b1, 5'd1, 32'h00100093, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b1, 1'b0, 4'hF, 5'd1, 32'h00100093, 1'b1, 16'd2};
    vecs[2]  = '{1'b1, 5'd2, 32'h00208113, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b1, 1'b0, 4'hF, 5'd2, 32'h00208113, 1'b1, 16'd3};
    vecs[3]  = '{1'b0, 5'd3, 32'h0,        1'b1, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b0, 1'b0, 4'h0, 5'd2, 32'h00208113, 1'b1, 16'd3};
    // HOLD: four cycles, no grants; core_reset falls on the 4th edge after ld_done.
    vecs[4]  = '{1'b1, 5'd9, 32'h11111111, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b0, 1'b0, 4'h0, 5'd2, 32'h00208113, 1'b1, 16'd3};
    vecs[5]  = '{1'b1, 5'd9, 32'h11111111, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b0, 1'b0, 4'h0, 5'd2, 32'h00208113, 1'b1, 16'd3};
    vecs[6]  = '{1'b1, 5'd9, 32'h11111111, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b0, 1'b0, 4'h0, 5'd2, 32'h00208113, 1'b1, 16'd3};
    vecs[7]  = '{1'b1, 5'd9, 32'h11111111, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b0, 1'b0, 4'h0, 5'd2, 32'h00208113, 1'b0, 16'd3};
    // RUN: both valid -> QED, LD, QED, LD.
    vecs[8]  = '{1'b1, 5'd9, 32'h11111111, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b0, 1'b1, 4'hF, 5'd7, 32'hAAAAAAAA, 1'b0, 16'd4};
    vecs[9]  = '{1'b1, 5'd9, 32'h11111111, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b1, 1'b0, 4'hF, 5'd9, 32'h11111111, 1'b0, 16'd5};
    vecs[10] = '{1'b1, 5'd9, 32'h11111111, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b0, 1'b1, 4'hF, 5'd7, 32'hAAAAAAAA, 1'b0, 16'd6};
    vecs[11] = '{1'b1, 5'd9, 32'h11111111, 1'b0, 1'b1, 5'd7, 32'hAAAAAAAA, 1'b1, 1'b0, 4'hF, 5'd9, 32'h11111111, 1'b0, 16'd7};
    // Lone requesters always win regardless of the pointer.
    vecs[12] = '{1'b1, 5'd10, 32'h22222222, 1'b0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 4'hF, 5'd10, 32'h22222222, 1'b0, 16'd8};
    vecs[13] = '{1'b1, 5'd11, 32'h33333333, 1'b0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 4'hF, 5'd11, 32'h33333333, 1'b0, 16'd9};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd12, 32'h44444444, 1'b0, 1'b1, 4'hF, 5'd12, 32'h44444444, 1'b0, 16'd10};
    // Idle cycle with ld_done (ignored in RUN): outputs hold, pointer unchanged.
    vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 4'h0, 5'd12, 32'h44444444, 1'b0, 16'd10};
    // Tie after a QED grant -> LD wins.
    vecs[16] = '{1'b1, 5'd13, 32'h55555555, 1'b0, 1'b1, 5'd14, 32'h66666666, 1'b1, 1'b0, 4'hF, 5'd13, 32'h55555555, 1'b0, 16'd11};

    // ---------------- reset state ----------------
    RESET = 1'b1; r1 = 1'b1;
    drive(1'b1, 5'd3, 32'h12345678, 1'b0, 1'b1, 5'd4, 32'h87654321);
    l1_vld = 1'b0; l1_addr = 5'd0; l1_data = 32'd0; l1_done = 1'b0;
    q1_vld = 1'b0; q1_addr = 5'd0; q1_data = 32'd0;
    @(posedge CLK); #1;
    chk("rst_ld_rdy", {31'd0, ld_rdy}, 32'd0);
    chk("rst_qed_rdy", {31'd0, qed_rdy}, 32'd0);
    chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
    RESET = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].dn, vecs[i].qv, vecs[i].qa, vecs[i].qd);
      #1;
      chk($sformatf("v%0d_ld_rdy", i), {31'd0, ld_rdy}, {31'd0, vecs[i].e_lr});
      chk($sformatf("v%0d_qed_rdy", i), {31'd0, qed_rdy}, {31'd0, vecs[i].e_qr});
      @(posedge CLK); #1;
      chk($sformatf("v%0d_mem_we", i), {28'd0, mem_we}, {28'd0, vecs[i].e_we});
      chk($sformatf("v%0d_mem_addr", i), {27'd0, mem_addr}, {27'd0, vecs[i].e_addr});
      chk($sformatf("v%0d_mem_data", i), mem_data, vecs[i].e_data);
      chk($sformatf("v%0d_core_reset", i), {31'd0, core_reset}, {31'd0, vecs[i].e_cr});
      chk($sformatf("v%0d_wr_count", i), {16'd0, wr_count}, {16'd0, vecs[i].e_cnt});
    end

    // ---------------- async reset mid-RUN while mem_we = F ----------------
    drive(1'b1, 5'd20, 32'h77777777, 1'b0, 1'b1, 5'd21, 32'h88888888);
    @(posedge CLK); #1;
    chk("arst_pre_we", {28'd0, mem_we}, 32'h0000000F);
    #2 RESET = 1'b1;
    #1;
    chk("arst_we", {28'd0, mem_we}, 32'd0);
    chk("arst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("arst_wr_count", {16'd0, wr_count}, 32'd0);
    chk("arst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("arst_ld_rdy", {31'd0, ld_rdy}, 32'd0);
    chk("arst_qed_rdy", {31'd0, qed_rdy}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    // back in LOAD: loader served, QED blocked
    chk("arst_load_ld_rdy", {31'd0, ld_rdy}, 32'd1);
    chk("arst_load_qed_rdy", {31'd0, qed_rdy}, 32'd0);
    @(posedge CLK); #1;
    chk("arst_first_grant_we", {28'd0, mem_we}, 32'h0000000F);
    chk("arst_first_grant_addr", {27'd0, mem_addr}, 32'd20);
    chk("arst_first_grant_cnt", {16'd0, wr_count}, 32'd1);

    // ---------------- ld_vld with ld_done in the same cycle ----------------
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 32'h0);
    @(posedge CLK); #1;
    chk("done_wr_we", {28'd0, mem_we}, 32'h0000000F);
    chk("done_wr_addr", {27'd0, mem_addr}, 32'd5);
    chk("done_wr_data", mem_data, 32'hDEADBEEF);
    drive(1'b1, 5'd6, 32'h99999999, 1'b0, 1'b1, 5'd8, 32'h12121212);
    #1;
    chk("done_hold_ld_rdy", {31'd0, ld_rdy}, 32'd0);
    chk("done_hold_qed_rdy", {31'd0, qed_rdy}, 32'd0);
    @(posedge CLK); #1;
    chk("done_hold_we", {28'd0, mem_we}, 32'd0);
    chk("done_hold_core_reset", {31'd0, core_reset}, 32'd1);

    // ---------------- HOLD_CYCLES = 1 ----------------
    @(negedge CLK);
    r1 = 1'b0;
    l1_done = 1'b1;
    @(posedge CLK); #1;
    l1_done = 1'b0;
    q1_vld = 1'b1; q1_addr = 5'd17; q1_data = 32'hCAFEF00D;
    chk("h1_hold_core_reset", {31'd0, cr1}, 32'd1);
    chk("h1_hold_qed_rdy", {31'd0, q1_rdy}, 32'd0);
    @(posedge CLK); #1;
    chk("h1_run_core_reset", {31'd0, cr1}, 32'd0);
    chk("h1_run_qed_rdy", {31'd0, q1_rdy}, 32'd1);
    @(posedge CLK); #1;
    chk("h1_run_we", {28'd0, m1_we}, 32'h0000000F);
    chk("h1_run_addr", {27'd0, m1_addr}, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_write_sched.md
IMEM_WRITE_SCHED -- requirements
Module: imem_write_sched

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, number of cycles core reset stays asserted after load completes (range 1..15).
REQ-002 Parameter: AW, default 5, instruction-memory word-address width (32-entry RAM).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 ld_vld  input  1  loader write request valid.
REQ-006 ld_addr  input  AW  loader word address.
REQ-007 ld_data  input  32  loader write data.
REQ-008 ld_done  input  1  loader end-of-program pulse.
REQ-009 ld_rdy  output  1  loader request accepted this cycle.
REQ-010 qed_vld  input  1  QED shim write request valid.
REQ-011 qed_addr  input  AW  QED word address.
REQ-012 qed_data  input  32  QED write data.
REQ-013 qed_rdy  output  1  QED request accepted this cycle.
REQ-014 mem_addr  output  AW  registered RAM port-A address.
REQ-015 mem_data  output  32  registered RAM port-A write data.
REQ-016 mem_we  output  4  registered RAM byte write enables, all four bits equal.
REQ-017 core_reset  output  1  registered reset to the core, active-high.
REQ-018 wr_count  output  16  number of writes issued to RAM since reset, saturating.

Function
REQ-019 The FSM SHALL have three states: LOAD, HOLD, RUN.
REQ-020 LOAD: only the loader is served. ld_rdy = ld_vld. qed_rdy = 0.
REQ-021 LOAD: on ld_done, the FSM SHALL go to HOLD and load the hold counter with HOLD_CYCLES.
REQ-022 LOAD: if ld_vld and ld_done are high in the same cycle, the write SHALL be accepted and the transition SHALL still occur.
REQ-023 HOLD: ld_rdy = qed_rdy = 0. The counter SHALL decrement each cycle. At count 1 the FSM SHALL go to RUN, so HOLD lasts exactly HOLD_CYCLES cycles.
REQ-024 RUN: round-robin arbitration between the loader and QED.
  - Exactly one requester SHALL be granted per cycle when any request is valid.
  - A lone requester SHALL always win.
  - On a tie, the requester not granted last SHALL win.
  - The priority pointer SHALL update only on a grant.
  - After reset the pointer SHALL favour QED.
REQ-025 RUN: ld_rdy and qed_rdy SHALL be combinational from the valids and the pointer, and SHALL never both be 1.
REQ-026 RUN: ld_done SHALL be ignored.
REQ-027 A grant in cycle N SHALL drive the following in cycle N+1, for exactly one cycle per accepted request:
  - mem_addr and mem_data = the granted address and data;
  - mem_we = 4'hF.
REQ-028 With no grant, mem_we SHALL be 4'h0, and mem_addr and mem_data SHALL hold their previous values.
REQ-029 core_reset SHALL be 1 in LOAD and HOLD. It SHALL be 0 from the first cycle the FSM is in RUN.
REQ-030 wr_count SHALL increment by one in the same cycle mem_we is nonzero, and SHALL saturate at 16'hFFFF.
REQ-031 Addresses SHALL pass through unmodified. Duplicate addresses SHALL cause no checking.
REQ-032 ld_rdy and qed_rdy SHALL be 0 while RESET is asserted.

Reset
REQ-033 On RESET asserted, regardless of clock, the block SHALL immediately set:
  - state = LOAD, core_reset = 1;
  - mem_we = 0, mem_addr = 0, mem_data = 0;
  - wr_count = 0, hold counter = 0;
  - RR pointer = QED.
REQ-034 When RESET asserts mid-HOLD or mid-RUN, the block SHALL abort and return to LOAD. An in-flight registered write SHALL be cleared (mem_we = 0) without issue.
REQ-035 After RESET deasserts, the first grant SHALL be possible on the first rising edge.

Verification
REQ-036 Load 3 words (addr 0, 1, 2, data 32'h00000013, 32'h00100093, 32'h00208113), then ld_done -> mem_we = F for 3 cycles, each 1 cycle after its grant; wr_count = 3; core_reset falls exactly 4 cycles after ld_done.
REQ-037 qed_vld held high during LOAD and HOLD -> qed_rdy = 0 throughout and no RAM write; first qed_rdy in the first RUN cycle.
REQ-038 RUN with ld_vld and qed_vld both continuously high for 4 cycles -> grants QED, LD, QED, LD; mem_addr follows each request one cycle later.
REQ-039 ld_vld with ld_done in the same cycle (addr 5, data 32'hDEADBEEF) -> write issued at addr 5, FSM enters HOLD.
REQ-040 RESET pulsed asynchronously mid-RUN while mem_we = F -> mem_we = 0 and core_reset = 1 before the next clock edge; wr_count = 0; state = LOAD.
REQ-041 HOLD_CYCLES = 1 -> core_reset deasserts 1 cycle after ld_done.
